// File: rtl/store_drain_buffer.sv
// In-order buffer for retired stores: drains them to the data-memory bus when loads
// leave it idle, and flags word-address conflicts for younger loads.
module store_drain_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [1:0]      store_command,
    input  logic [1:0]      store_size,
    input  logic [XLEN-1:0] store_addr,
    input  logic [XLEN-1:0] store_data,
    output logic            full,
    output logic            empty,
    input  logic            load_req,
    input  logic [XLEN-1:0] lookup_addr,
    output logic            lookup_conflict,
    input  logic            halt_drain,
    output logic            drained,
    output logic [1:0]      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output logic [63:0]     proc2mem_data,
    output logic [1:0]      proc2mem_size,
    input  logic [3:0]      mem2proc_response
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF      = 2'd1;

    typedef enum logic [1:0] {NORMAL, FLUSH, DONE} state_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [XLEN-1:0]  addr_q [DEPTH];
    logic [XLEN-1:0]  addr_d [DEPTH];
    logic [XLEN-1:0]  data_q [DEPTH];
    logic [XLEN-1:0]  data_d [DEPTH];
    logic [1:0]       size_q [DEPTH];
    logic [1:0]       size_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    state_t           state_q, state_d;
    logic             full_q, full_d, empty_q, empty_d, drained_q, drained_d;
    logic             enq, issue, deq;
    logic             lookup_unused;

    function automatic logic [63:0] replicate(input logic [1:0] sz, input logic [XLEN-1:0] d);
        case (sz)
            BYTE:    return {8{d[7:0]}};
            HALF:    return {4{d[15:0]}};
            default: return {2{d[31:0]}};
        endcase
    endfunction

    always_comb begin
        issue = !empty_q && (!load_req || state_q == FLUSH);
        enq   = (store_command == BUS_STORE) && !full_q && (state_q != DONE);
        deq   = issue && (mem2proc_response != 4'd0);

        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        size_d  = size_q;
        head_d  = head_q;
        tail_d  = tail_q;

        if (deq) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + PTR_W'(1);
        end
        if (enq) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = store_addr;
            data_d[tail_q]  = store_data;
            size_d[tail_q]  = store_size;
            tail_d          = tail_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(enq) - CNT_W'(deq);

        // A store accepted alongside halt must still drain, so it forces FLUSH rather than DONE.
        state_d = state_q;
        case (state_q)
            NORMAL:  if (halt_drain) state_d = (count_q != '0 || enq) ? FLUSH : DONE;
            FLUSH:   if (count_d == '0) state_d = DONE;
            default: state_d = state_q;
        endcase

        full_d    = (count_d == CNT_W'(DEPTH));
        empty_d   = (count_d == '0);
        drained_d = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= NORMAL;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            drained_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            size_q    <= size_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            drained_q <= drained_d;
        end
    end

    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        proc2mem_size    = '0;
        if (issue) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = addr_q[head_q];
            proc2mem_data    = replicate(size_q[head_q], data_q[head_q]);
            proc2mem_size    = size_q[head_q];
        end
    end

    // The entry being dequeued this cycle is still valid here, so it still blocks the load.
    always_comb begin
        lookup_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && addr_q[i][XLEN-1:2] == lookup_addr[XLEN-1:2]) begin
                lookup_conflict = 1'b1;
            end
        end
    end

    assign lookup_unused = ^lookup_addr[1:0];
    assign full          = full_q;
    assign empty         = empty_q;
    assign drained       = drained_q;

    enq_legal: assert property (@(posedge clock) disable iff (reset)
        (store_command == BUS_STORE) |-> (!full_q && state_q != DONE));

endmodule

// File: tb/tb_store_drain_buffer.sv
// Scoreboard bench for store_drain_buffer: expected bus stores are queued at enqueue
// and compared when the memory accepts them.
module tb_store_drain_buffer;

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam logic [1:0] BYTE      = 2'd0;
    localparam logic [1:0] HALF      = 2'd1;
    localparam logic [1:0] WORD      = 2'd2;

    logic        clock;
    logic        reset;
    logic [1:0]  store_command;
    logic [1:0]  store_size;
    logic [31:0] store_addr;
    logic [31:0] store_data;
    logic        full;
    logic        empty;
    logic        load_req;
    logic [31:0] lookup_addr;
    logic        lookup_conflict;
    logic        halt_drain;
    logic        drained;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data;
    logic [1:0]  proc2mem_size;
    logic [3:0]  mem2proc_response;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [1:0]  size;
    } txn_t;

    txn_t exp_q[$];
    txn_t exp_t;
    int   tests_run    = 0;
    int   tests_failed = 0;

    store_drain_buffer #(.DEPTH(4), .XLEN(32)) dut (
        .clock             (clock),
        .reset             (reset),
        .store_command     (store_command),
        .store_size        (store_size),
        .store_addr        (store_addr),
        .store_data        (store_data),
        .full              (full),
        .empty             (empty),
        .load_req          (load_req),
        .lookup_addr       (lookup_addr),
        .lookup_conflict   (lookup_conflict),
        .halt_drain        (halt_drain),
        .drained           (drained),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .proc2mem_data     (proc2mem_data),
        .proc2mem_size     (proc2mem_size),
        .mem2proc_response (mem2proc_response)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] expect_lanes(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            BYTE:    return {8{d[7:0]}};
            HALF:    return {4{d[15:0]}};
            default: return {d, d};
        endcase
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        store_command     = BUS_NONE;
        load_req          = 1'b0;
        halt_drain        = 1'b0;
        mem2proc_response = 4'd0;
        step();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic drive_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        store_command = BUS_STORE;
        store_size    = sz;
        store_addr    = a;
        store_data    = d;
        exp_q.push_back('{addr: a, data: expect_lanes(sz, d), size: sz});
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        store_command = BUS_STORE;
        store_size    = WORD;
        store_addr    = 32'h0;
        store_data    = 32'h1;
        step();
        store_command = BUS_NONE;
        step();
        reset       = 1'b0;
        lookup_addr = 32'h0;
        #1;
        tests_run++;
        if ({full, empty, drained, lookup_conflict} !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got full/empty/drained/conflict=%b, expected 0100",
                     {full, empty, drained, lookup_conflict});
        end
        tests_run++;
        if ({proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bus: got cmd=%0d addr=%h data=%h size=%0d, expected all zero",
                     proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size);
        end
    endtask

    task automatic test_basic_drain();
        do_reset();
        mem2proc_response = 4'd1;
        drive_store(WORD, 32'h100, 32'hDEADBEEF);
        #1;
        tests_run++;
        if (proc2mem_command !== BUS_NONE) begin
            tests_failed++;
            $display("[TB] FAIL basic_no_bypass: got cmd=%0d, expected %0d", proc2mem_command, BUS_NONE);
        end
        step();
        store_command = BUS_NONE;
        #1;
        tests_run++;
        if ({proc2mem_command, proc2mem_addr, proc2mem_data} !== {BUS_STORE, 32'h100, 64'hDEADBEEF_DEADBEEF}) begin
            tests_failed++;
            $display("[TB] FAIL basic_bus: got cmd=%0d addr=%h data=%h, expected cmd=2 addr=100 data=deadbeefdeadbeef",
                     proc2mem_command, proc2mem_addr, proc2mem_data);
        end
        if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
            tests_run++;
            exp_t = exp_q.pop_front();
            if ({proc2mem_addr, proc2mem_data, proc2mem_size} !== {exp_t.addr, exp_t.data, exp_t.size}) begin
                tests_failed++;
                $display("[TB] FAIL basic_sb: got addr=%h data=%h size=%0d, expected addr=%h data=%h size=%0d",
                         proc2mem_addr, proc2mem_data, proc2mem_size, exp_t.addr, exp_t.data, exp_t.size);
            end
        end
        step();
        tests_run++;
        if ({empty, proc2mem_command} !== {1'b1, BUS_NONE}) begin
            tests_failed++;
            $display("[TB] FAIL basic_after: got empty=%b cmd=%0d, expected empty=1 cmd=0", empty, proc2mem_command);
        end
    endtask

    task automatic test_fill_stall();
        logic [1:0] sizes [4];
        sizes = '{WORD, HALF, BYTE, WORD};
        do_reset();
        load_req          = 1'b1;
        mem2proc_response = 4'd1;
        for (int i = 0; i < 4; i++) begin
            drive_store(sizes[i], 32'h200 + 32'(8 * i), $urandom);
            #1;
            tests_run++;
            if (proc2mem_command !== BUS_NONE) begin
                tests_failed++;
                $display("[TB] FAIL fill_stalled: got cmd=%0d, expected 0 (entry %0d)", proc2mem_command, i);
            end
            step();
        end
        store_command = BUS_NONE;
        #1;
        tests_run++;
        if ({full, proc2mem_command} !== {1'b1, BUS_NONE}) begin
            tests_failed++;
            $display("[TB] FAIL fill_full: got full=%b cmd=%0d, expected full=1 cmd=0", full, proc2mem_command);
        end
        load_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests_run++;
            if (proc2mem_command !== BUS_STORE) begin
                tests_failed++;
                $display("[TB] FAIL fill_issue: got cmd=%0d, expected 2 (cycle %0d)", proc2mem_command, i);
            end
            if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
                tests_run++;
                exp_t = exp_q.pop_front();
                if ({proc2mem_addr, proc2mem_data, proc2mem_size} !== {exp_t.addr, exp_t.data, exp_t.size}) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_sb: got addr=%h data=%h size=%0d, expected addr=%h data=%h size=%0d",
                             proc2mem_addr, proc2mem_data, proc2mem_size, exp_t.addr, exp_t.data, exp_t.size);
                end
            end
            step();
            if (i == 0) begin
                tests_run++;
                if (full !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL fill_full_clears: got full=%b, expected 0", full);
                end
            end
        end
        tests_run++;
        if (empty !== 1'b1 || exp_q.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL fill_all_drained: got empty=%b pending=%0d, expected empty=1 pending=0",
                     empty, exp_q.size());
        end
    endtask

    task automatic test_reject_retry();
        do_reset();
        mem2proc_response = 4'd0;
        drive_store(HALF, 32'h22, 32'h1234);
        step();
        store_command = BUS_NONE;
        for (int k = 0; k < 4; k++) begin
            mem2proc_response = (k < 3) ? 4'd0 : 4'd2;
            #1;
            tests_run++;
            if ({proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size} !==
                {BUS_STORE, 32'h22, 64'h1234123412341234, HALF}) begin
                tests_failed++;
                $display("[TB] FAIL retry_bus: got cmd=%0d addr=%h data=%h size=%0d, expected 2 22 1234123412341234 1 (cycle %0d)",
                         proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size, k);
            end
            if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
                tests_run++;
                exp_t = exp_q.pop_front();
                if ({proc2mem_addr, proc2mem_data, proc2mem_size} !== {exp_t.addr, exp_t.data, exp_t.size}) begin
                    tests_failed++;
                    $display("[TB] FAIL retry_sb: got addr=%h data=%h, expected addr=%h data=%h",
                             proc2mem_addr, proc2mem_data, exp_t.addr, exp_t.data);
                end
            end
            step();
            if (k < 3) begin
                tests_run++;
                if (empty !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL retry_held: got empty=%b, expected 0 after reject %0d", empty, k);
                end
            end
        end
        tests_run++;
        if ({empty, proc2mem_command} !== {1'b1, BUS_NONE}) begin
            tests_failed++;
            $display("[TB] FAIL retry_single_dequeue: got empty=%b cmd=%0d, expected empty=1 cmd=0",
                     empty, proc2mem_command);
        end
        mem2proc_response = 4'd1;
        drive_store(BYTE, 32'h31, 32'h000000AB);
        step();
        store_command = BUS_NONE;
        #1;
        tests_run++;
        if (proc2mem_data !== 64'hABABABABABABABAB) begin
            tests_failed++;
            $display("[TB] FAIL byte_lanes: got data=%h, expected abababababababab", proc2mem_data);
        end
        if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
            tests_run++;
            exp_t = exp_q.pop_front();
            if ({proc2mem_addr, proc2mem_size} !== {exp_t.addr, exp_t.size}) begin
                tests_failed++;
                $display("[TB] FAIL byte_sb: got addr=%h size=%0d, expected addr=%h size=%0d",
                         proc2mem_addr, proc2mem_size, exp_t.addr, exp_t.size);
            end
        end
        step();
    endtask

    task automatic test_conflict();
        logic [31:0] probes [3];
        logic        hits   [3];
        probes = '{32'h106, 32'h108, 32'h103};
        hits   = '{1'b1, 1'b0, 1'b0};
        do_reset();
        load_req          = 1'b1;
        mem2proc_response = 4'd1;
        drive_store(WORD, 32'h104, 32'h55);
        step();
        store_command = BUS_NONE;
        for (int i = 0; i < 3; i++) begin
            lookup_addr = probes[i];
            #1;
            tests_run++;
            if (lookup_conflict !== hits[i]) begin
                tests_failed++;
                $display("[TB] FAIL conflict_probe: got conflict=%b for %h, expected %b",
                         lookup_conflict, probes[i], hits[i]);
            end
        end
        lookup_addr = 32'h106;
        load_req    = 1'b0;
        #1;
        tests_run++;
        if (lookup_conflict !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL conflict_while_dequeue: got conflict=%b, expected 1", lookup_conflict);
        end
        if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
            tests_run++;
            exp_t = exp_q.pop_front();
            if ({proc2mem_addr, proc2mem_data} !== {exp_t.addr, exp_t.data}) begin
                tests_failed++;
                $display("[TB] FAIL conflict_sb: got addr=%h data=%h, expected addr=%h data=%h",
                         proc2mem_addr, proc2mem_data, exp_t.addr, exp_t.data);
            end
        end
        step();
        tests_run++;
        if (lookup_conflict !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL conflict_after_drain: got conflict=%b, expected 0", lookup_conflict);
        end
    endtask

    task automatic test_halt_flush();
        do_reset();
        load_req          = 1'b1;
        mem2proc_response = 4'd1;
        for (int i = 0; i < 3; i++) begin
            drive_store(WORD, 32'h400 + 32'(4 * i), $urandom);
            step();
        end
        store_command = BUS_NONE;
        halt_drain    = 1'b1;
        #1;
        tests_run++;
        if ({proc2mem_command, drained} !== {BUS_NONE, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL halt_first_cycle: got cmd=%0d drained=%b, expected cmd=0 drained=0",
                     proc2mem_command, drained);
        end
        step();
        for (int k = 0; k < 3; k++) begin
            #1;
            tests_run++;
            if ({proc2mem_command, drained} !== {BUS_STORE, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL flush_issue: got cmd=%0d drained=%b, expected cmd=2 drained=0 (store %0d)",
                         proc2mem_command, drained, k);
            end
            if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
                tests_run++;
                exp_t = exp_q.pop_front();
                if ({proc2mem_addr, proc2mem_data} !== {exp_t.addr, exp_t.data}) begin
                    tests_failed++;
                    $display("[TB] FAIL flush_sb: got addr=%h data=%h, expected addr=%h data=%h",
                             proc2mem_addr, proc2mem_data, exp_t.addr, exp_t.data);
                end
            end
            step();
        end
        tests_run++;
        if ({drained, empty, proc2mem_command} !== {1'b1, 1'b1, BUS_NONE}) begin
            tests_failed++;
            $display("[TB] FAIL flush_drained: got drained=%b empty=%b cmd=%0d, expected 1 1 0",
                     drained, empty, proc2mem_command);
        end
        halt_drain = 1'b0;
        step();
        tests_run++;
        if (drained !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL done_hold: got drained=%b, expected 1", drained);
        end
        do_reset();
        halt_drain = 1'b1;
        #1;
        tests_run++;
        if (drained !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL halt_empty_early: got drained=%b, expected 0", drained);
        end
        step();
        tests_run++;
        if (drained !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL halt_empty_drained: got drained=%b, expected 1", drained);
        end
        halt_drain = 1'b0;
    endtask

    task automatic test_enqueue_with_halt();
        do_reset();
        load_req          = 1'b1;
        mem2proc_response = 4'd1;
        drive_store(WORD, 32'h40, 32'hCAFEF00D);
        halt_drain = 1'b1;
        step();
        store_command = BUS_NONE;
        #1;
        tests_run++;
        if ({drained, proc2mem_command} !== {1'b0, BUS_STORE}) begin
            tests_failed++;
            $display("[TB] FAIL halt_enq_flush: got drained=%b cmd=%0d, expected drained=0 cmd=2",
                     drained, proc2mem_command);
        end
        if (proc2mem_command === BUS_STORE && mem2proc_response != 4'd0) begin
            tests_run++;
            exp_t = exp_q.pop_front();
            if ({proc2mem_addr, proc2mem_data} !== {exp_t.addr, exp_t.data}) begin
                tests_failed++;
                $display("[TB] FAIL halt_enq_sb: got addr=%h data=%h, expected addr=%h data=%h",
                         proc2mem_addr, proc2mem_data, exp_t.addr, exp_t.data);
            end
        end
        step();
        tests_run++;
        if (drained !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL halt_enq_drained: got drained=%b, expected 1", drained);
        end
        halt_drain = 1'b0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        load_req          = 1'b1;
        mem2proc_response = 4'd0;
        drive_store(WORD, 32'h300, 32'h11111111);
        step();
        drive_store(WORD, 32'h304, 32'h22222222);
        step();
        store_command = BUS_NONE;
        halt_drain    = 1'b1;
        step();
        #1;
        tests_run++;
        if (proc2mem_command !== BUS_STORE) begin
            tests_failed++;
            $display("[TB] FAIL midflush_issuing: got cmd=%0d, expected 2", proc2mem_command);
        end
        reset             = 1'b1;
        halt_drain        = 1'b0;
        load_req          = 1'b0;
        mem2proc_response = 4'd1;
        step();
        reset       = 1'b0;
        lookup_addr = 32'h300;
        exp_q.delete();
        #1;
        tests_run++;
        if ({full, empty, drained, lookup_conflict} !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL midflush_flags: got full/empty/drained/conflict=%b, expected 0100",
                     {full, empty, drained, lookup_conflict});
        end
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({proc2mem_command, proc2mem_addr, proc2mem_data, proc2mem_size} !== '0) begin
                tests_failed++;
                $display("[TB] FAIL midflush_no_issue: got cmd=%0d addr=%h data=%h, expected all zero (cycle %0d)",
                         proc2mem_command, proc2mem_addr, proc2mem_data, k);
            end
            step();
            #1;
        end
    endtask

    initial begin
        reset             = 1'b1;
        store_command     = BUS_NONE;
        store_size        = WORD;
        store_addr        = '0;
        store_data        = '0;
        load_req          = 1'b0;
        lookup_addr       = '0;
        halt_drain        = 1'b0;
        mem2proc_response = 4'd0;
        test_reset();
        test_basic_drain();
        test_fill_stall();
        test_reject_retry();
        test_conflict();
        test_halt_flush();
        test_enqueue_with_halt();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
